// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared instruction-size table for the PC sequencer and control FSM
package pc_pkg;

  localparam logic [1:0] SIZE_1 = 2'd1;
  localparam logic [1:0] SIZE_2 = 2'd2;
  localparam logic [1:0] SIZE_3 = 2'd3;

  localparam int unsigned OP_SZ2_78 = 32'h78;
  localparam int unsigned OP_SZ2_80 = 32'h80;
  localparam int unsigned OP_SZ2_81 = 32'h81;
  localparam int unsigned OP_SZ2_82 = 32'h82;
  localparam int unsigned OP_SZ2_84 = 32'h84;
  localparam int unsigned OP_SZ2_85 = 32'h85;
  localparam int unsigned OP_SZ2_87 = 32'h87;
  localparam int unsigned OP_SZ2_C0 = 32'hC0;
  localparam int unsigned OP_SZ1_83 = 32'h83;

  // Opcode is passed zero-extended so any OPCODE_WIDTH up to 32 shares this table.
  function automatic logic [1:0] opcode_size(input int unsigned op);
    case (op)
      OP_SZ2_78, OP_SZ2_80, OP_SZ2_81, OP_SZ2_82,
      OP_SZ2_84, OP_SZ2_85, OP_SZ2_87, OP_SZ2_C0: return SIZE_2;
      OP_SZ1_83:                                  return SIZE_1;
      default:                                    return SIZE_3;
    endcase
  endfunction

endpackage

// File: rtl/return_addr_stack.sv
// rtl/return_addr_stack.sv - circular LIFO of return addresses with saturating count
module return_addr_stack #(
  parameter int RAS_DEPTH = 4,
  parameter int PC_WIDTH  = 6
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                push,
  input  logic                pop,
  input  logic [PC_WIDTH-1:0] push_data,
  output logic [PC_WIDTH-1:0] top,
  output logic                empty,
  output logic                full,
  output logic                overflow,
  output logic                underflow
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PC_WIDTH-1:0] mem_q [RAS_DEPTH];
  logic [PTR_W-1:0]    wptr_q, wptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ovf_q, ovf_d;
  logic                unf_q, unf_d;

  assign empty     = (cnt_q == '0);
  assign full      = (cnt_q == CNT_W'(RAS_DEPTH));
  assign overflow  = ovf_q;
  assign underflow = unf_q;
  assign top       = mem_q[wptr_q - PTR_W'(1)];

  // When full, the write pointer already sits on the oldest entry, so a push overwrites it.
  always_comb begin
    wptr_d = wptr_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    unf_d  = unf_q;
    if (push) begin
      wptr_d = wptr_q + PTR_W'(1);
      if (full) ovf_d = 1'b1;
      else      cnt_d = cnt_q + CNT_W'(1);
    end else if (pop) begin
      if (empty) begin
        unf_d = 1'b1;
      end else begin
        wptr_d = wptr_q - PTR_W'(1);
        cnt_d  = cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr_q <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem_q[wptr_q] <= push_data;
  end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter with size decode, jump, call/return and stall
module pc_sequencer import pc_pkg::*; #(
  parameter int PC_WIDTH     = 6,
  parameter int OPCODE_WIDTH = 8,
  parameter int RAS_DEPTH    = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    pc_stall,
  input  logic                    pc_load,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic                    jump_valid,
  input  logic                    call_valid,
  input  logic                    ret_valid,
  input  logic [PC_WIDTH-1:0]     jump_target,
  output logic [PC_WIDTH-1:0]     pc,
  output logic [1:0]              instr_size,
  output logic                    ras_empty,
  output logic                    ras_full,
  output logic                    ras_overflow,
  output logic                    ras_underflow
);

  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] pc_inc;
  logic [PC_WIDTH-1:0] ras_top;
  logic                ras_push, ras_pop;

  assign instr_size = opcode_size(32'(opcode));
  assign pc_inc     = pc_q + {{(PC_WIDTH-2){1'b0}}, instr_size};
  assign pc         = pc_q;

  return_addr_stack #(
    .RAS_DEPTH (RAS_DEPTH),
    .PC_WIDTH  (PC_WIDTH)
  ) u_ras (
    .clock     (clock),
    .reset     (reset),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc_inc),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full),
    .overflow  (ras_overflow),
    .underflow (ras_underflow)
  );

  // Strictly one action per edge; lower-priority strobes have no side effects.
  always_comb begin
    pc_d     = pc_q;
    ras_push = 1'b0;
    ras_pop  = 1'b0;
    if (pc_stall) begin
      pc_d = pc_q;
    end else if (ret_valid) begin
      ras_pop = 1'b1;
      pc_d    = ras_empty ? pc_inc : ras_top;
    end else if (call_valid) begin
      ras_push = 1'b1;
      pc_d     = jump_target;
    end else if (jump_valid) begin
      pc_d = jump_target;
    end else if (pc_load) begin
      pc_d = pc_inc;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) pc_q <= '0;
    else       pc_q <= pc_d;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Parametrised next-generation program counter for the 8086-style core.
- Advances the PC by the decoded instruction length (1/2/3 words).
- Adds stall, absolute jump, call/return via an internal return-address stack (RAS), and sticky overflow/underflow flags.
- Sits between the control FSM, which drives the advance/jump/call/ret strobes, and instruction memory, which is addressed by pc.

Parameters:
- PC_WIDTH, 6, width of the PC and of all addresses; 2^PC_WIDTH words of program space.
- OPCODE_WIDTH, 8, width of the opcode input.
- RAS_DEPTH, 4, number of return-address entries; power of two, ≥2.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- pc_stall  in  1  freeze the PC and the RAS this cycle; overrides all other strobes
- pc_load  in  1  advance PC by instruction size of opcode
- opcode  in  OPCODE_WIDTH  opcode of the instruction currently at pc
- jump_valid  in  1  load jump_target into PC
- call_valid  in  1  push return address and load jump_target
- ret_valid  in  1  pop RAS into PC
- jump_target  in  PC_WIDTH  absolute target for jump/call
- pc  out  PC_WIDTH  registered program counter
- instr_size  out  2  combinational size of the current opcode (1..3)
- ras_empty  out  1  RAS holds 0 entries
- ras_full  out  1  RAS holds RAS_DEPTH entries
- ras_overflow  out  1  sticky: a call was made while the RAS was full
- ras_underflow  out  1  sticky: a ret was made while the RAS was empty

Behaviour:
- Reset (async, any time, including mid-operation):
  - pc=0, RAS count=0, write pointer=0.
  - ras_empty=1, ras_full=0, ras_overflow=0, ras_underflow=0.
  - RAS entry contents are don't-care.
- Size decode (combinational):
  - 0x78, 0x80, 0x81, 0x82, 0x84, 0x85, 0x87, 0xC0 → 2.
  - 0x83 → 1.
  - All other opcodes → 3.
  - The size is zero-extended to PC_WIDTH before the add.
- Next-PC priority, one action per rising edge, evaluated highest first:
  1. pc_stall → pc and RAS hold.
  2. ret_valid:
     - RAS non-empty → pc ← top entry; count−1.
     - RAS empty → pc ← pc+instr_size; set ras_underflow.
  3. call_valid:
     - Push pc+instr_size (mod 2^PC_WIDTH), then pc ← jump_target.
     - RAS full → overwrite the oldest entry (circular); count stays RAS_DEPTH; set ras_overflow.
  4. jump_valid → pc ← jump_target.
  5. pc_load → pc ← pc+instr_size.
  6. No strobe → pc holds.
- Latency: new pc is visible the cycle after the strobe edge; a pushed entry can be popped on the very next cycle.
- Arithmetic: all pc adds wrap modulo 2^PC_WIDTH with no carry-out (e.g. PC_WIDTH=6: 63+2=1).
- RAS is LIFO: circular buffer with a write pointer and a saturating count.
  - Top entry = the slot at write pointer−1.
  - Push writes at the write pointer, then increments it.
  - Pop decrements the write pointer.
- Flags:
  - ras_empty = (count==0); ras_full = (count==RAS_DEPTH).
  - Both are derived from registered count and update with it.
  - ras_overflow and ras_underflow are cleared only by reset.
- Simultaneous strobes are legal; the lower-priority strobe is ignored with no side effects, so call+ret means only the ret executes.
- No simulation-only $display in synthesizable code.

Decomposition:
- Shared package pc_pkg:
  - Size constants SIZE_1/2/3.
  - Named opcode localparams for the 2-word and 1-word opcodes listed above.
  - A function for opcode→size so the decoder and the control FSM share one table.
- One sub-module, return_addr_stack:
  - Parameters RAS_DEPTH, PC_WIDTH.
  - Ports push, pop, push_data, top, empty, full, overflow, underflow.
  - Holds the circular buffer, pointer and count.
- The top level holds the pc register, size decode and priority mux.

Test Plan:
1. Reset then pc_load with opcodes 0x83, 0x80, 0x01 → pc: 0→1→3→6; instr_size 1, 2, 3.
2. Wrap:
   - Drive pc to 62 via jump (target 62), then pc_load with opcode 0x01.
   - pc=1 (62+3 mod 64).
3. Call/ret:
   - At pc=4 with opcode 0x80 (size 2), call_valid with target 40 → pc=40, ras_empty=0.
   - Then ret_valid → pc=6, ras_empty=1.
4. RAS overflow:
   - With RAS_DEPTH=4, perform 5 nested calls from pcs 0, 10, 20, 30, 40, opcode 0x01 each time.
   - ras_full=1, ras_overflow=1.
   - 4 rets return 43, 33, 23, 13; a 5th ret sets ras_underflow=1 and advances pc by size.
5. Priority/stall:
   - Assert pc_stall, ret_valid, call_valid and pc_load together → pc and RAS unchanged.
   - Then jump_valid + pc_load with target 20 → pc=20.
6. Async reset mid-call:
   - Assert reset between clock edges after two pushes.
   - pc=0, ras_empty=1 and both flags=0 immediately, without waiting for a clock edge.
